// File: rtl/mem_access_stage.sv
// MEM stage: multi-cycle data memory access with stall generation and the MEM/WB register.
// Optional alignment fault detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adder,
    input  logic [31:0] ALU,
    input  logic        zf,
    input  logic [31:0] RD2,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [4:0]  Mux5,
    output logic        pcsrc,
    output logic [31:0] branch_pc,
    output logic        stall,
    output logic [1:0]  sWB,
    output logic [31:0] sReadData,
    output logic [31:0] sALU,
    output logic [4:0]  sMux5,
    output logic        misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_complete;
    logic                   w_memop;
    logic                   w_load;
    logic                   w_store;
    logic                   w_fault;
    logic [ADDR_BITS-1:0]   w_addr;
    logic                   w_unused;
    logic [31:0]            r_mem [0:(2**ADDR_BITS)-1];

    // MemRead wins when both MemRead and MemWrite are set
    assign w_memop   = M[1] | M[0];
    assign w_load    = M[1];
    assign w_store   = M[0] & ~M[1];
    assign w_addr    = ALU[ADDR_BITS+1:2];
    assign w_unused  = ^{ALU[31:ADDR_BITS+2], ALU[1:0]};

    assign pcsrc     = M[2] & zf;
    assign branch_pc = Adder;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault = w_memop && (ALU[1:0] != 2'b00);
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Reset forces stall low and blocks completion, so no write can slip through
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        w_complete  = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_memop && HAS_WAIT) begin
                        stall       = 1'b1;
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = WAIT_INIT;
                    end else begin
                        w_complete  = 1'b1;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        stall       = 1'b1;
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_complete && w_store && !w_fault) begin
            r_mem[w_addr] <= RD2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sWB       <= '0;
            sReadData <= '0;
            sALU      <= '0;
            sMux5     <= '0;
            misalign  <= 1'b0;
        end else if (stall) begin
            sWB       <= '0;
            misalign  <= 1'b0;
        end else if (w_complete) begin
            sWB       <= w_fault ? 2'b00 : WB;
            sALU      <= ALU;
            sMux5     <= Mux5;
            sReadData <= w_load ? r_mem[w_addr] : '0;
            misalign  <= w_fault;
        end
    end

endmodule
